// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle for the sequential ALU.
//   start, op, A, B      : request side, driven by the control unit (master)
//   R, isZero, isNegative,
//   ovfl, bad_op         : registered result and flags, driven by the ALU (slave)
//   busy, done           : handshake status, driven by the ALU (slave)
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] R;
    logic             isZero;
    logic             isNegative;
    logic             ovfl;
    logic             bad_op;
    logic             busy;
    logic             done;

    modport master (
        output start, op, A, B,
        input  R, isZero, isNegative, ovfl, bad_op, busy, done
    );

    modport slave (
        input  start, op, A, B,
        output R, isZero, isNegative, ovfl, bad_op, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle logic/arithmetic ops and
// multi-cycle iterative shifts (1 bit per clock) and shift-add multiply.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : alu_seq_if slave modport (start/op/A/B in; R, flags, busy, done out)
// A request is accepted when start=1 and busy=0 at a rising edge. Results
// and flags are registered and held until the next completion; done pulses
// for one cycle after the completing edge.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input logic      clk,
    input logic      reset,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;   // must hold WIDTH for the multiply count

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_NAND = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t state, state_next;

    // Latched request and iteration state
    logic [3:0]       op_q;
    logic [WIDTH-1:0] mcand;     // multiplicand (A) for MUL
    logic [WIDTH-1:0] acc_hi;    // upper product half for MUL
    logic [WIDTH-1:0] acc_lo;    // shifting value, or multiplier/lower product half
    logic [CW-1:0]    cnt;       // iterations still to run

    // Registered outputs
    logic [WIDTH-1:0] r_q;
    logic             zero_q, neg_q, ovfl_q, bad_q, done_q;
    logic             busy;

    logic             accept, is_iter, go_exec, last_iter;
    logic [CW-1:0]    n_start;
    logic [WIDTH-1:0] sum, diff;
    logic             add_ovfl, sub_ovfl;
    logic [WIDTH-1:0] sc_res;
    logic             sc_ovfl, sc_bad;
    logic [WIDTH-1:0] it_hi, it_lo;
    logic [WIDTH:0]   mul_sum;

    assign accept    = bus.start && !busy;
    assign is_iter   = bus.op inside {OP_SLL, OP_SRL, OP_SRA, OP_MUL};
    assign n_start   = (bus.op == OP_MUL) ? CW'(WIDTH) : CW'(bus.B[SHW-1:0]);
    // A zero-length shift needs no iterations and completes like a 1-cycle op.
    assign go_exec   = is_iter && (n_start != '0);
    assign last_iter = (cnt == CW'(1));

    assign sum      = bus.A + bus.B;
    assign diff     = bus.A - bus.B;
    assign add_ovfl = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1]  != bus.A[WIDTH-1]);
    assign sub_ovfl = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);

    // Result of every op that completes on the accepting edge.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        sc_res  = '0;
        sc_ovfl = 1'b0;
        sc_bad  = 1'b0;
        case (bus.op)
            OP_AND:  sc_res = bus.A & bus.B;
            OP_OR:   sc_res = bus.A | bus.B;
            OP_ADD:  begin sc_res = sum;  sc_ovfl = add_ovfl; end
            OP_SUB:  begin sc_res = diff; sc_ovfl = sub_ovfl; end
            OP_XOR:  sc_res = bus.A ^ bus.B;
            OP_NOR:  sc_res = ~(bus.A | bus.B);
            OP_NAND: sc_res = ~(bus.A & bus.B);
            // Raw difference sign; ovfl reports the subtraction overflow only.
            OP_SLT:  begin sc_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1]}; sc_ovfl = sub_ovfl; end
            OP_SLL, OP_SRL, OP_SRA: sc_res = bus.A;   // only used when the amount is 0
            OP_MUL:  sc_res = '0;                     // always iterates
            default: sc_bad = 1'b1;                   // undefined op: R=0, bad_op=1
        endcase
    end

    // One iteration of the latched multi-cycle op.
    always_comb begin
        it_hi   = acc_hi;
        it_lo   = acc_lo;
        mul_sum = '0;
        case (op_q)
            OP_SLL: it_lo = {acc_lo[WIDTH-2:0], 1'b0};
            OP_SRL: it_lo = {1'b0, acc_lo[WIDTH-1:1]};
            OP_SRA: it_lo = {acc_lo[WIDTH-1], acc_lo[WIDTH-1:1]};
            OP_MUL: begin
                // Add the multiplicand when the current multiplier bit is set,
                // then shift the whole {carry, hi, lo} product right by one.
                mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
                {it_hi, it_lo} = {mul_sum, acc_lo[WIDTH-1:1]};
            end
            default: ;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && go_exec) state_next = EXEC;
            EXEC:    if (last_iter)         state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state == EXEC);
    end

    // Datapath and registered results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= '0;
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            r_q    <= '0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovfl_q <= 1'b0;
            bad_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    op_q   <= bus.op;
                    mcand  <= bus.A;
                    acc_hi <= '0;
                    acc_lo <= (bus.op == OP_MUL) ? bus.B : bus.A;
                    cnt    <= n_start;
                    if (!go_exec) begin
                        r_q    <= sc_res;
                        zero_q <= (sc_res == '0);
                        neg_q  <= sc_res[WIDTH-1];
                        ovfl_q <= sc_ovfl;
                        bad_q  <= sc_bad;
                        done_q <= 1'b1;
                    end
                end
            end else begin
                acc_hi <= it_hi;
                acc_lo <= it_lo;
                cnt    <= cnt - CW'(1);
                if (last_iter) begin
                    r_q    <= it_lo;
                    zero_q <= (it_lo == '0);
                    neg_q  <= it_lo[WIDTH-1];
                    // Nonzero upper product half means the result did not fit.
                    ovfl_q <= (op_q == OP_MUL) && (it_hi != '0);
                    bad_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.R          = r_q;
    assign bus.isZero     = zero_q;
    assign bus.isNegative = neg_q;
    assign bus.ovfl       = ovfl_q;
    assign bus.bad_op     = bad_q;
    assign bus.busy       = busy;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq. Directed scenarios plus
// randomized ops compared against an arithmetic reference model.
module tb_alu_seq;
    localparam int W = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // {R, isZero, isNegative, ovfl, bad_op}
    typedef struct packed {
        logic [W-1:0] r;
        logic         z;
        logic         neg;
        logic         ovfl;
        logic         bad;
    } res_t;

    function automatic res_t observed();
        return {bus.R, bus.isZero, bus.isNegative, bus.ovfl, bus.bad_op};
    endfunction

    // Reference model: plain integer arithmetic on the operand values.
    function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, output int lat);
        longint       sa, sb, s;
        longint       p;
        logic [W-1:0] r;
        logic         ov, bad;
        int           n;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        n   = int'(b[3:0]);
        r   = '0;
        ov  = 1'b0;
        bad = 1'b0;
        lat = 1;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: begin s = sa + sb; r = s[W-1:0]; ov = (s > 32767) || (s < -32768); end
            4'd3: begin s = sa - sb; r = s[W-1:0]; ov = (s > 32767) || (s < -32768); end
            4'd4: r = a ^ b;
            4'd5: r = ~(a | b);
            4'd6: r = ~(a & b);
            4'd7: begin s = sa - sb; r = {15'd0, s[15]}; ov = (s > 32767) || (s < -32768); end
            4'd8: begin r = a << n; lat = n + 1; end
            4'd9: begin r = a >> n; lat = n + 1; end
            4'd10: begin r = $signed(a) >>> n; lat = n + 1; end
            4'd11: begin
                p   = longint'(a) * longint'(b);
                r   = p[W-1:0];
                ov  = (p >> W) != 0;
                lat = W + 1;
            end
            default: bad = 1'b1;
        endcase
        return {r, (r == '0), r[W-1], ov, bad};
    endfunction

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h0000;
            default: return W'($urandom);
        endcase
    endfunction

    // Present a request before an edge; return #1 after the accepting edge
    // with operands scrambled so the DUT cannot rely on them afterwards.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 4'($urandom);
        bus.A     = W'($urandom);
        bus.B     = W'($urandom);
    endtask

    // Count cycles after accept until done (cycle 1 = cycle after the accepting edge).
    task automatic wait_done(output int cyc, output int bcyc);
        cyc  = 1;
        bcyc = 0;
        while (!bus.done && cyc < 200) begin
            if (bus.busy) bcyc++;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        res_t got;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (2) @(posedge clk);
        #1;
        got = observed();
        n_tests++;
        if ({got, bus.busy, bus.done} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h busy=%b done=%b, want all zero", got, bus.busy, bus.done);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if ({observed(), bus.busy, bus.done} !== '0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %h busy=%b done=%b, want all zero", observed(), bus.busy, bus.done);
        end
    endtask

    task automatic test_add_ovfl();
        int cyc, bcyc;
        issue(4'd2, 16'h7FFF, 16'h0001);
        wait_done(cyc, bcyc);
        n_tests++;
        if (cyc !== 1 || bcyc !== 0) begin
            n_fail++;
            $display("FAIL add_latency: got lat=%0d busy=%0d, want lat=1 busy=0", cyc, bcyc);
        end
        n_tests++;
        if (observed() !== {16'h8000, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL add_ovfl: got %h, want %h", observed(), {16'h8000, 4'b0110});
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.done !== 1'b0 || bus.R !== 16'h8000) begin
            n_fail++;
            $display("FAIL add_hold: got done=%b R=%h, want done=0 R=8000", bus.done, bus.R);
        end
    endtask

    task automatic test_sub_slt();
        int cyc, bcyc;
        issue(4'd3, 16'd5, 16'd5);
        wait_done(cyc, bcyc);
        n_tests++;
        if (observed() !== {16'h0000, 4'b1000}) begin
            n_fail++;
            $display("FAIL sub_zero: got %h, want %h", observed(), {16'h0000, 4'b1000});
        end
        issue(4'd7, 16'hFFFD, 16'h0002);
        wait_done(cyc, bcyc);
        n_tests++;
        if (observed() !== {16'h0001, 4'b0000} || cyc !== 1) begin
            n_fail++;
            $display("FAIL slt_neg: got %h lat=%0d, want %h lat=1", observed(), cyc, {16'h0001, 4'b0000});
        end
    endtask

    task automatic test_busy_ignore();
        int   cyc, bcyc, pulses;
        logic b1;
        issue(4'd10, 16'h8000, 16'd4);
        b1 = bus.busy;
        // Second request while busy must be dropped.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 4'd2;
        bus.A     = 16'h0001;
        bus.B     = 16'h0001;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc  = 2;
        bcyc = b1 ? 1 : 0;
        while (!bus.done && cyc < 200) begin
            if (bus.busy) bcyc++;
            @(posedge clk);
            #1;
            cyc++;
        end
        n_tests++;
        if (cyc !== 5 || bcyc !== 4) begin
            n_fail++;
            $display("FAIL sra_timing: got lat=%0d busy=%0d, want lat=5 busy=4", cyc, bcyc);
        end
        n_tests++;
        if (observed() !== {16'hF800, 4'b0100}) begin
            n_fail++;
            $display("FAIL sra_result: got %h, want %h", observed(), {16'hF800, 4'b0100});
        end
        pulses = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
        n_tests++;
        if (pulses !== 0 || bus.R !== 16'hF800) begin
            n_fail++;
            $display("FAIL busy_ignore: got extra_done=%0d R=%h, want 0 and F800", pulses, bus.R);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bcyc;
        issue(4'd11, 16'd300, 16'd300);
        wait_done(cyc, bcyc);
        n_tests++;
        if (cyc !== 17 || bcyc !== 16) begin
            n_fail++;
            $display("FAIL mul_timing: got lat=%0d busy=%0d, want lat=17 busy=16", cyc, bcyc);
        end
        n_tests++;
        if (observed() !== {16'h5F90, 4'b0010}) begin
            n_fail++;
            $display("FAIL mul_ovfl: got %h, want %h", observed(), {16'h5F90, 4'b0010});
        end
        // Still in the done cycle: the next request must be accepted.
        issue(4'd11, 16'd3, 16'd7);
        wait_done(cyc, bcyc);
        n_tests++;
        if (cyc !== 17 || observed() !== {16'd21, 4'b0000}) begin
            n_fail++;
            $display("FAIL mul_b2b: got %h lat=%0d, want %h lat=17", observed(), cyc, {16'd21, 4'b0000});
        end
    endtask

    task automatic test_reset_mid();
        int cyc, bcyc;
        issue(4'd11, 16'h1234, 16'h00F7);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_busy_mid: got busy=%b, want 1", bus.busy);
        end
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({observed(), bus.busy, bus.done} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %h busy=%b done=%b, want all zero", observed(), bus.busy, bus.done);
        end
        @(negedge clk);
        reset = 1'b0;
        issue(4'd4, 16'h00FF, 16'h0F0F);
        wait_done(cyc, bcyc);
        n_tests++;
        if (cyc !== 1 || observed() !== {16'h0FF0, 4'b0000}) begin
            n_fail++;
            $display("FAIL xor_after_reset: got %h lat=%0d, want %h lat=1", observed(), cyc, {16'h0FF0, 4'b0000});
        end
    endtask

    task automatic test_bad_op();
        int cyc, bcyc;
        issue(4'd12, 16'h1234, 16'h5678);
        wait_done(cyc, bcyc);
        n_tests++;
        if (cyc !== 1 || observed() !== {16'h0000, 4'b1001}) begin
            n_fail++;
            $display("FAIL bad_op: got %h lat=%0d, want %h lat=1", observed(), cyc, {16'h0000, 4'b1001});
        end
        issue(4'd1, 16'd1, 16'd2);
        wait_done(cyc, bcyc);
        n_tests++;
        if (observed() !== {16'd3, 4'b0000}) begin
            n_fail++;
            $display("FAIL bad_op_clear: got %h, want %h", observed(), {16'd3, 4'b0000});
        end
    endtask

    // Randomized requests drawn from [lo_op, hi_op], checked against the model.
    task automatic test_random(input string name, input int count, input int lo_op, input int hi_op);
        int           cyc, bcyc, lat;
        logic [3:0]   op;
        logic [W-1:0] a, b;
        res_t         exp_r;
        for (int i = 0; i < count; i++) begin
            op    = 4'($urandom_range(hi_op, lo_op));
            a     = rand_operand();
            b     = rand_operand();
            exp_r = model(op, a, b, lat);
            issue(op, a, b);
            wait_done(cyc, bcyc);
            n_tests++;
            if (observed() !== exp_r) begin
                n_fail++;
                $display("FAIL %s_result op=%0d a=%h b=%h: got %h, want %h", name, op, a, b, observed(), exp_r);
            end
            n_tests++;
            if (cyc !== lat || bcyc !== lat - 1) begin
                n_fail++;
                $display("FAIL %s_timing op=%0d b=%h: got lat=%0d busy=%0d, want lat=%0d busy=%0d",
                         name, op, b, cyc, bcyc, lat, lat - 1);
            end
            @(posedge clk);
            #1;
            n_tests++;
            if (bus.done !== 1'b0 || observed() !== exp_r) begin
                n_fail++;
                $display("FAIL %s_hold op=%0d: got done=%b %h, want done=0 %h", name, op, bus.done, observed(), exp_r);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_ovfl();
        test_sub_slt();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_bad_op();
        test_random("single", 40, 0, 7);
        test_random("shift", 24, 8, 10);
        test_random("mul", 8, 11, 11);
        test_random("undef", 6, 12, 15);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
